mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 21 ++
 rtl/mem_responder_if.sv | 44 ++++
 rtl/mem_resp_queue.sv | 66 ++++++
 rtl/mem_responder.sv | 82 ++++++++
 tb/tb_mem_responder.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: op encoding and the default
// response-queue entry layout.
package mem_responder_pkg;

    typedef enum logic {
        MEM_OP_READ  = 1'b0,
        MEM_OP_WRITE = 1'b1
    } mem_op_e;

    localparam int unsigned MEM_ADDR_BITS = 32;
    localparam int unsigned MEM_DATA_BITS = 32;
    localparam int unsigned MEM_OPAQ_BITS = 8;

    typedef struct packed {
        mem_op_e                  op;
        logic [MEM_OPAQ_BITS-1:0] opaque;
        logic [MEM_ADDR_BITS-1:0] addr;
        logic [MEM_DATA_BITS-1:0] data;
    } mem_resp_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request, response and backdoor-preload signals of the memory responder.
// Handshake: a beat transfers on a rising edge where valid && ready; the
// sender holds valid and payload stable until then, and ready never
// depends combinationally on valid.
interface mem_responder_if #(
    parameter int unsigned p_addr_bits = 32,
    parameter int unsigned p_data_bits = 32,
    parameter int unsigned p_opaq_bits = 8
);
    logic                   req_val;
    logic                   req_rdy;
    logic                   req_op;
    logic [p_opaq_bits-1:0] req_opaque;
    logic [p_addr_bits-1:0] req_addr;
    logic [p_data_bits-1:0] req_data;

    logic                   resp_val;
    logic                   resp_rdy;
    logic                   resp_op;
    logic [p_opaq_bits-1:0] resp_opaque;
    logic [p_addr_bits-1:0] resp_addr;
    logic [p_data_bits-1:0] resp_data;

    logic                   init_val;
    logic [p_addr_bits-1:0] init_addr;
    logic [p_data_bits-1:0] init_data;

    modport master (
        output req_val, req_op, req_opaque, req_addr, req_data,
        output resp_rdy,
        output init_val, init_addr, init_data,
        input  req_rdy,
        input  resp_val, resp_op, resp_opaque, resp_addr, resp_data
    );

    modport slave (
        input  req_val, req_op, req_opaque, req_addr, req_data,
        input  resp_rdy,
        input  init_val, init_addr, init_data,
        output req_rdy,
        output resp_val, resp_op, resp_opaque, resp_addr, resp_data
    );

endinterface

// File: rtl/mem_resp_queue.sv
// In-order response FIFO; full/valid come straight from the registered count,
// so neither flag has a combinational path from the enqueue/dequeue strobes.
module mem_resp_queue
    import mem_responder_pkg::*;
#(
    parameter int unsigned p_depth = 2,
    parameter type         entry_t = mem_resp_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   enq_val_i,
    input  entry_t enq_data_i,
    output logic   full_o,
    input  logic   deq_rdy_i,
    output logic   deq_val_o,
    output entry_t deq_data_o
);

    localparam int unsigned    PW         = $clog2(p_depth);
    localparam logic [PW-1:0]  PTR_ONE    = PW'(1);
    localparam logic [PW:0]    COUNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]    FULL_COUNT = (PW+1)'(p_depth);

    entry_t        slots_q [p_depth];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          enq_fire, deq_fire;

    assign deq_val_o  = (count_q != '0);
    assign full_o     = (count_q == FULL_COUNT);
    assign enq_fire   = enq_val_i && !full_o;
    assign deq_fire   = deq_val_o && deq_rdy_i;
    assign deq_data_o = slots_q[head_q];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq_fire) tail_d = tail_q + PTR_ONE;
        if (deq_fire) head_d = head_q + PTR_ONE;
        case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) slots_q[tail_q] <= enq_data_i;
    end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory that answers each accepted read/write with one
// in-order response; a backdoor init port preloads words without responding.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned p_addr_bits   = 32,
    parameter int unsigned p_data_bits   = 32,
    parameter int unsigned p_opaq_bits   = 8,
    parameter int unsigned p_num_words   = 256,
    parameter int unsigned p_queue_depth = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam int unsigned IW = $clog2(p_num_words);

    typedef struct packed {
        mem_op_e                op;
        logic [p_opaq_bits-1:0] opaque;
        logic [p_addr_bits-1:0] addr;
        logic [p_data_bits-1:0] data;
    } resp_entry_t;

    logic [p_data_bits-1:0] mem_q [p_num_words];
    logic [IW-1:0]          req_idx, init_idx;
    logic                   req_fire, wr_fire, q_full, rdy_en_q;
    mem_op_e                req_op;
    resp_entry_t            enq_entry, head_entry;
    logic                   unused_addr_bits;

    assign req_idx  = bus.req_addr[2 +: IW];
    assign init_idx = bus.init_addr[2 +: IW];
    assign req_op   = mem_op_e'(bus.req_op);
    assign unused_addr_bits = ^{bus.req_addr, bus.init_addr};

    // rdy_en_q holds req_rdy low through reset and the edge that releases it.
    assign bus.req_rdy = rdy_en_q && !q_full;
    assign req_fire    = bus.req_val && bus.req_rdy;
    assign wr_fire     = req_fire && (req_op == MEM_OP_WRITE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_en_q <= 1'b0;
        else     rdy_en_q <= 1'b1;
    end

    // Reads capture the pre-edge word; the write and init land on the same edge.
    always_comb begin
        enq_entry        = '0;
        enq_entry.op     = req_op;
        enq_entry.opaque = bus.req_opaque;
        enq_entry.addr   = bus.req_addr;
        enq_entry.data   = (req_op == MEM_OP_WRITE) ? '0 : mem_q[req_idx];
    end

    // Storage is deliberately outside reset; init is last so it wins a collision.
    always_ff @(posedge clk) begin
        if (wr_fire)      mem_q[req_idx]  <= bus.req_data;
        if (bus.init_val) mem_q[init_idx] <= bus.init_data;
    end

    mem_resp_queue #(
        .p_depth (p_queue_depth),
        .entry_t (resp_entry_t)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .enq_val_i  (req_fire),
        .enq_data_i (enq_entry),
        .full_o     (q_full),
        .deq_rdy_i  (bus.resp_rdy),
        .deq_val_o  (bus.resp_val),
        .deq_data_o (head_entry)
    );

    assign bus.resp_op     = head_entry.op;
    assign bus.resp_opaque = head_entry.opaque;
    assign bus.resp_addr   = head_entry.addr;
    assign bus.resp_data   = head_entry.data;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus random traffic, scored
// against a word-array memory model and an expected-response queue.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int AB = 32;
    localparam int DB = 32;
    localparam int OB = 8;
    localparam int NW = 256;
    localparam int QD = 2;
    localparam int EW = 1 + OB + AB + DB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_responder_if #(.p_addr_bits(AB), .p_data_bits(DB), .p_opaq_bits(OB)) bus();

    mem_responder #(
        .p_addr_bits(AB), .p_data_bits(DB), .p_opaq_bits(OB),
        .p_num_words(NW), .p_queue_depth(QD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [DB-1:0] ref_mem [NW];
    logic [EW-1:0] exp_q[$];
    bit            ref_alive;
    int            checks   = 0;
    int            failures = 0;

    function automatic int word_of(input logic [AB-1:0] a);
        return int'((a >> 2) % NW);
    endfunction

    task automatic drive_idle();
        bus.req_val    = 1'b0;
        bus.req_op     = 1'b0;
        bus.req_opaque = '0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.init_val   = 1'b0;
        bus.init_addr  = '0;
        bus.init_data  = '0;
    endtask

    task automatic drive_req(input logic op, input logic [AB-1:0] a,
                             input logic [DB-1:0] d, input logic [OB-1:0] t);
        bus.req_val    = 1'b1;
        bus.req_op     = op;
        bus.req_addr   = a;
        bus.req_data   = d;
        bus.req_opaque = t;
    endtask

    // One clock: score handshakes visible now, update the model, advance.
    task automatic tick(output bit req_fired);
        logic [EW-1:0] e;
        logic [DB-1:0] rd;
        bit rf, df, exp_rdy;
        rf = (bus.req_val === 1'b1) && (bus.req_rdy === 1'b1);
        df = (bus.resp_val === 1'b1) && (bus.resp_rdy === 1'b1);
        exp_rdy = ref_alive && (exp_q.size() < QD);
        checks++;
        if (bus.resp_val !== (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL resp_val: got %b expected %b", bus.resp_val, exp_q.size() != 0);
        end
        checks++;
        if (bus.req_rdy !== exp_rdy) begin
            failures++;
            $display("FAIL req_rdy: got %b expected %b", bus.req_rdy, exp_rdy);
        end
        if (df && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({bus.resp_op, bus.resp_opaque, bus.resp_addr, bus.resp_data} !== e) begin
                failures++;
                $display("FAIL resp_payload: got op=%b opq=%h addr=%h data=%h expected op=%b opq=%h addr=%h data=%h",
                         bus.resp_op, bus.resp_opaque, bus.resp_addr, bus.resp_data,
                         e[EW-1], e[AB+DB +: OB], e[DB +: AB], e[0 +: DB]);
            end
        end
        if (rf) begin
            rd = bus.req_op ? '0 : ref_mem[word_of(bus.req_addr)];
            exp_q.push_back({bus.req_op, bus.req_opaque, bus.req_addr, rd});
            if (bus.req_op) ref_mem[word_of(bus.req_addr)] = bus.req_data;
        end
        if (bus.init_val) ref_mem[word_of(bus.init_addr)] = bus.init_data;
        ref_alive = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_fired = rf;
    endtask

    task automatic test_reset();
        bit f;
        rst = 1'b1;
        drive_idle();
        bus.resp_rdy = 1'b1;
        exp_q.delete();
        ref_alive = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.resp_val, bus.req_rdy} !== 2'b00) begin
            failures++;
            $display("FAIL reset_outputs: got val/rdy=%b expected 00", {bus.resp_val, bus.req_rdy});
        end
        rst = 1'b0;
        tick(f);
        checks++;
        if (bus.req_rdy !== 1'b1) begin
            failures++;
            $display("FAIL rdy_after_reset: got %b expected 1", bus.req_rdy);
        end
    endtask

    task automatic preload_all();
        bit f;
        for (int i = 0; i < NW; i++) begin
            bus.init_val  = 1'b1;
            bus.init_addr = AB'(i * 4);
            bus.init_data = (i == 64) ? 32'hdeadbeef : $urandom;
            tick(f);
        end
        drive_idle();
    endtask

    task automatic test_preload_read();
        bit f;
        drive_req(1'b0, 32'h100, '0, 8'h5);
        tick(f);
        drive_idle();
        checks++;
        if ({f, bus.resp_val, bus.resp_op, bus.resp_opaque, bus.resp_addr, bus.resp_data} !==
            {1'b1, 1'b1, 1'b0, 8'h5, 32'h100, 32'hdeadbeef}) begin
            failures++;
            $display("FAIL preload_read: got acc=%b val=%b op=%b opq=%h addr=%h data=%h expected 1 1 0 05 00000100 deadbeef",
                     f, bus.resp_val, bus.resp_op, bus.resp_opaque, bus.resp_addr, bus.resp_data);
        end
        tick(f);
    endtask

    task automatic test_back_to_back();
        bit f;
        drive_req(1'b1, 32'h8, 32'hcafef00d, 8'h1);
        tick(f);
        checks++;
        if ({bus.resp_val, bus.resp_op, bus.resp_data} !== {1'b1, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL b2b_write_resp: got val=%b op=%b data=%h expected 1 1 00000000",
                     bus.resp_val, bus.resp_op, bus.resp_data);
        end
        drive_req(1'b0, 32'h8, '0, 8'h2);
        tick(f);
        drive_idle();
        checks++;
        if ({bus.resp_val, bus.resp_op, bus.resp_data} !== {1'b1, 1'b0, 32'hcafef00d}) begin
            failures++;
            $display("FAIL b2b_read_resp: got val=%b op=%b data=%h expected 1 0 cafef00d",
                     bus.resp_val, bus.resp_op, bus.resp_data);
        end
        tick(f);
    endtask

    task automatic test_backpressure();
        bit f;
        int n;
        n = 0;
        bus.resp_rdy = 1'b0;
        for (int c = 0; c < 6 && n < 2; c++) begin
            drive_req(1'b0, AB'(32'h10 + 4 * n), '0, OB'(8'h20 + n));
            tick(f);
            if (f) n++;
        end
        drive_req(1'b0, 32'h18, '0, 8'h22);
        checks++;
        if (n != 2 || bus.req_rdy !== 1'b0) begin
            failures++;
            $display("FAIL bp_full: got accepts=%0d rdy=%b expected 2 0", n, bus.req_rdy);
        end
        for (int c = 0; c < 3; c++) begin
            tick(f);
            checks++;
            if ({f, bus.resp_val, bus.resp_data} !== {1'b0, 1'b1, ref_mem[4]}) begin
                failures++;
                $display("FAIL bp_stall: got acc=%b val=%b data=%h expected 0 1 %h",
                         f, bus.resp_val, bus.resp_data, ref_mem[4]);
            end
        end
        bus.resp_rdy = 1'b1;
        f = 1'b0;
        for (int c = 0; c < 8 && !f; c++) tick(f);
        checks++;
        if (!f) begin
            failures++;
            $display("FAIL bp_third_accept: got not accepted expected accepted within 8 cycles");
        end
        drive_idle();
        repeat (3) tick(f);
    endtask

    task automatic test_alias();
        bit f;
        drive_req(1'b0, 32'h400, '0, 8'h7);
        tick(f);
        drive_idle();
        checks++;
        if ({bus.resp_val, bus.resp_addr, bus.resp_data} !== {1'b1, 32'h400, ref_mem[0]}) begin
            failures++;
            $display("FAIL alias_read: got val=%b addr=%h data=%h expected 1 00000400 %h",
                     bus.resp_val, bus.resp_addr, bus.resp_data, ref_mem[0]);
        end
        tick(f);
    endtask

    task automatic test_init_collision();
        bit f;
        drive_req(1'b1, 32'h40, 32'h11112222, 8'h9);
        bus.init_val  = 1'b1;
        bus.init_addr = 32'h42;
        bus.init_data = 32'h5a5a0001;
        tick(f);
        drive_idle();
        drive_req(1'b0, 32'h40, '0, 8'ha);
        tick(f);
        drive_idle();
        checks++;
        if ({bus.resp_val, bus.resp_data} !== {1'b1, 32'h5a5a0001}) begin
            failures++;
            $display("FAIL init_wins: got val=%b data=%h expected 1 5a5a0001", bus.resp_val, bus.resp_data);
        end
        tick(f);
    endtask

    task automatic test_random();
        bit f;
        for (int c = 0; c < 400; c++) begin
            bus.req_val    = ($urandom_range(0, 2) != 0);
            bus.req_op     = $urandom_range(0, 1);
            bus.req_addr   = ($urandom_range(0, 3) == 0) ? $urandom : AB'($urandom_range(0, 63));
            bus.req_data   = $urandom;
            bus.req_opaque = OB'($urandom);
            bus.resp_rdy   = ($urandom_range(0, 3) != 0);
            bus.init_val   = ($urandom_range(0, 5) == 0);
            bus.init_addr  = ($urandom_range(0, 1) == 0) ? bus.req_addr : AB'($urandom_range(0, 63));
            bus.init_data  = $urandom;
            tick(f);
        end
        drive_idle();
        bus.resp_rdy = 1'b1;
        repeat (4) tick(f);
    endtask

    task automatic test_reset_mid();
        bit f;
        logic [DB-1:0] v;
        v = $urandom;
        bus.resp_rdy = 1'b1;
        drive_req(1'b1, 32'h20, v, 8'hb);
        tick(f);
        drive_idle();
        tick(f);
        bus.resp_rdy = 1'b0;
        drive_req(1'b0, 32'h20, '0, 8'hc);
        tick(f);
        drive_req(1'b0, 32'h24, '0, 8'hd);
        tick(f);
        drive_idle();
        rst = 1'b1;
        exp_q.delete();
        ref_alive = 1'b0;
        #1;
        checks++;
        if ({bus.resp_val, bus.req_rdy} !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset: got val/rdy=%b expected 00", {bus.resp_val, bus.req_rdy});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.resp_rdy = 1'b1;
        tick(f);
        drive_req(1'b0, 32'h20, '0, 8'he);
        tick(f);
        drive_idle();
        checks++;
        if ({bus.resp_val, bus.resp_data} !== {1'b1, v}) begin
            failures++;
            $display("FAIL storage_kept: got val=%b data=%h expected 1 %h", bus.resp_val, bus.resp_data, v);
        end
        repeat (2) tick(f);
    endtask

    initial begin
        test_reset();
        preload_all();
        test_preload_read();
        test_back_to_back();
        test_backpressure();
        test_alias();
        test_init_collision();
        test_random();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d responses outstanding expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
